// File: rtl/life_grid_rules.sv
// Game-of-Life grid with runtime outer-totalistic rule (Bxx/Sxx), toroidal or dead edges,
// load/step control and generation/population counters. Optional macro: LIFE_STILL_DETECT_EN.
module life_grid_rules #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned WRAP   = 1,
  parameter int unsigned GEN_W  = 16,
  parameter int unsigned POP_W  = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [WIDTH*HEIGHT-1:0]   init,
  input  logic                      step,
  input  logic [8:0]                birth_mask,
  input  logic [8:0]                survive_mask,
  output logic [WIDTH*HEIGHT-1:0]   states,
  output logic [GEN_W-1:0]          generation,
  output logic [POP_W-1:0]          population,
  output logic                      pop_valid,
  output logic                      still
);

  localparam int unsigned N = WIDTH * HEIGHT;

  logic [N-1:0]     r_states;
  logic [N-1:0]     w_next;
  logic [GEN_W-1:0] r_gen;
  logic [POP_W-1:0] r_pop;
  logic             r_pop_valid;

  function automatic logic [3:0] count9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + 4'(v[i]);
    return s;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [N-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N); i++) s = s + POP_W'(v[i]);
    return s;
  endfunction

  // Next-generation logic: neighbour indices resolved at elaboration, edge handling by WRAP
  for (genvar r = 0; r < int'(HEIGHT); r++) begin : g_row
    for (genvar c = 0; c < int'(WIDTH); c++) begin : g_col
      logic [8:0] w_nb;
      logic [3:0] w_cnt;
      for (genvar k = 0; k < 9; k++) begin : g_nb
        localparam int RR  = r + (k / 3) - 1;
        localparam int CC  = c + (k % 3) - 1;
        localparam int RW  = (RR + int'(HEIGHT)) % int'(HEIGHT);
        localparam int CW  = (CC + int'(WIDTH)) % int'(WIDTH);
        localparam bit INR = (RR >= 0) && (RR < int'(HEIGHT)) && (CC >= 0) && (CC < int'(WIDTH));
        if (k == 4) begin : g_self
          assign w_nb[k] = 1'b0;
        end else if ((WRAP != 0) || INR) begin : g_live
          assign w_nb[k] = r_states[RW*int'(WIDTH) + CW];
        end else begin : g_dead
          assign w_nb[k] = 1'b0;
        end
      end
      assign w_cnt = count9(w_nb);
      assign w_next[r*int'(WIDTH) + c] = r_states[r*int'(WIDTH) + c] ? survive_mask[w_cnt]
                                                                       : birth_mask[w_cnt];
    end
  end

  // Grid, counters and population; priority reset > load > step
  always_ff @(posedge clock) begin
    if (reset) begin
      r_states    <= '0;
      r_gen       <= '0;
      r_pop       <= '0;
      r_pop_valid <= 1'b1;
    end else begin
      r_pop <= popcount(r_states);
      if (load) begin
        r_states    <= init;
        r_gen       <= '0;
        r_pop_valid <= 1'b0;
      end else if (step) begin
        r_states    <= w_next;
        r_gen       <= r_gen + GEN_W'(1);
        r_pop_valid <= 1'b0;
      end else begin
        r_pop_valid <= 1'b1;
      end
    end
  end

`ifdef LIFE_STILL_DETECT_EN
  logic r_still;

  // Set on a step that leaves the grid unchanged; held until the next step/load/reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_still <= 1'b0;
    end else if (load) begin
      r_still <= 1'b0;
    end else if (step) begin
      r_still <= (w_next == r_states);
    end
  end

  assign still = r_still;
`else
  assign still = 1'b0;
`endif

  assign states     = r_states;
  assign generation = r_gen;
  assign population = r_pop;
  assign pop_valid  = r_pop_valid;

endmodule

// File: tb/tb_life_grid_rules.sv
// Directed testbench for life_grid_rules: several small grid instances sharing control inputs.
module tb_life_grid_rules;

`ifdef LIFE_STILL_DETECT_EN
  localparam bit STILL_EN = 1'b1;
`else
  localparam bit STILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, load, step;
  logic [8:0] birth, survive;

  logic [24:0] i5w, i5d, s5w, s5d;
  logic [15:0] i4w, i4d, ig, s4w, s4d, sg;
  logic [63:0] i8, s8;
  logic [15:0] g5w, g5d, g4w, g4d, g8;
  logic [2:0]  gg;
  logic [4:0]  p5w, p5d, p4w, p4d, pg;
  logic [6:0]  p8;
  logic v5w, v5d, v4w, v4d, v8, vg;
  logic t5w, t5d, t4w, t4d, t8, tg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  life_grid_rules #(.WIDTH(5), .HEIGHT(5), .WRAP(1)) d5w (
    .clock(clk), .reset(reset), .load(load), .init(i5w), .step(step), .birth_mask(birth),
    .survive_mask(survive), .states(s5w), .generation(g5w), .population(p5w),
    .pop_valid(v5w), .still(t5w));
  life_grid_rules #(.WIDTH(5), .HEIGHT(5), .WRAP(0)) d5d (
    .clock(clk), .reset(reset), .load(load), .init(i5d), .step(step), .birth_mask(birth),
    .survive_mask(survive), .states(s5d), .generation(g5d), .population(p5d),
    .pop_valid(v5d), .still(t5d));
  life_grid_rules #(.WIDTH(4), .HEIGHT(4), .WRAP(1)) d4w (
    .clock(clk), .reset(reset), .load(load), .init(i4w), .step(step), .birth_mask(birth),
    .survive_mask(survive), .states(s4w), .generation(g4w), .population(p4w),
    .pop_valid(v4w), .still(t4w));
  life_grid_rules #(.WIDTH(4), .HEIGHT(4), .WRAP(0)) d4d (
    .clock(clk), .reset(reset), .load(load), .init(i4d), .step(step), .birth_mask(birth),
    .survive_mask(survive), .states(s4d), .generation(g4d), .population(p4d),
    .pop_valid(v4d), .still(t4d));
  life_grid_rules #(.WIDTH(8), .HEIGHT(8), .WRAP(1)) d8 (
    .clock(clk), .reset(reset), .load(load), .init(i8), .step(step), .birth_mask(birth),
    .survive_mask(survive), .states(s8), .generation(g8), .population(p8),
    .pop_valid(v8), .still(t8));
  life_grid_rules #(.WIDTH(4), .HEIGHT(4), .WRAP(1), .GEN_W(3)) dg (
    .clock(clk), .reset(reset), .load(load), .init(ig), .step(step), .birth_mask(birth),
    .survive_mask(survive), .states(sg), .generation(gg), .population(pg),
    .pop_valid(vg), .still(tg));

  // One clock: inputs change at negedge, outputs are sampled at the following negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load();
    load = 1'b1; tick(); load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; step = 1'b1;
    i5w = 25'h1FFFFFF; i5d = '0; i4w = '0; i4d = '0; i8 = '0; ig = '0;
    birth = 9'h008; survive = 9'h00C;
    tick(); tick();
    checks++; if (s5w !== 25'h0) begin failures++; $display("FAIL rst_over_load got=%h exp=0", s5w); end
    checks++; if (v5w !== 1'b1) begin failures++; $display("FAIL rst_pv got=%b exp=1", v5w); end
    checks++; if (t5w !== 1'b0) begin failures++; $display("FAIL rst_still got=%b exp=0", t5w); end
    reset = 1'b0; step = 1'b0; i5w = '0;
    tick();
    load = 1'b0; tick();
    checks++; if (s5w !== 25'h0) begin failures++; $display("FAIL load0_states got=%h exp=0", s5w); end
    checks++; if (g5w !== 16'd0) begin failures++; $display("FAIL load0_gen got=%0d exp=0", g5w); end
    checks++; if (p5w !== 5'd0) begin failures++; $display("FAIL load0_pop got=%0d exp=0", p5w); end
    checks++; if (v5w !== 1'b1) begin failures++; $display("FAIL load0_pv got=%b exp=1", v5w); end
  endtask

  task automatic test_blinker();
    logic [24:0] horiz, vert;
    horiz = '0; horiz[11] = 1'b1; horiz[12] = 1'b1; horiz[13] = 1'b1;
    vert  = '0; vert[7]   = 1'b1; vert[12]  = 1'b1; vert[17]  = 1'b1;
    birth = 9'h008; survive = 9'h00C; i5w = horiz;
    do_load();
    checks++; if (v5w !== 1'b0) begin failures++; $display("FAIL blk_load_pv got=%b exp=0", v5w); end
    step = 1'b1; tick(); step = 1'b0;
    checks++; if (s5w !== vert) begin failures++; $display("FAIL blk_vert got=%h exp=%h", s5w, vert); end
    checks++; if (g5w !== 16'd1) begin failures++; $display("FAIL blk_gen1 got=%0d exp=1", g5w); end
    checks++; if (v5w !== 1'b0) begin failures++; $display("FAIL blk_step_pv got=%b exp=0", v5w); end
    tick();
    checks++; if (p5w !== 5'd3 || v5w !== 1'b1) begin failures++; $display("FAIL blk_pop1 got=%0d/%b exp=3/1", p5w, v5w); end
    step = 1'b1; tick(); step = 1'b0; tick();
    checks++; if (s5w !== horiz) begin failures++; $display("FAIL blk_horiz got=%h exp=%h", s5w, horiz); end
    checks++; if (g5w !== 16'd2) begin failures++; $display("FAIL blk_gen2 got=%0d exp=2", g5w); end
    checks++; if (p5w !== 5'd3) begin failures++; $display("FAIL blk_pop2 got=%0d exp=3", p5w); end
  endtask

  task automatic test_corners();
    logic [15:0] corners;
    corners = 16'h9009;
    birth = 9'h008; survive = 9'h00C; i4w = corners; i4d = corners;
    do_load();
    step = 1'b1; tick(); step = 1'b0;
    checks++; if (s4w !== corners) begin failures++; $display("FAIL cor_wrap got=%h exp=%h", s4w, corners); end
    checks++; if (t4w !== STILL_EN) begin failures++; $display("FAIL cor_still got=%b exp=%b", t4w, STILL_EN); end
    checks++; if (s4d !== 16'h0) begin failures++; $display("FAIL cor_dead got=%h exp=0", s4d); end
    checks++; if (t4d !== 1'b0) begin failures++; $display("FAIL cor_dead_still got=%b exp=0", t4d); end
    checks++; if (g4w !== 16'd1 || g4d !== 16'd1) begin failures++; $display("FAIL cor_gen got=%0d/%0d exp=1/1", g4w, g4d); end
    tick();
    checks++; if (p4w !== 5'd4 || v4w !== 1'b1) begin failures++; $display("FAIL cor_pop_wrap got=%0d/%b exp=4/1", p4w, v4w); end
    checks++; if (p4d !== 5'd0 || v4d !== 1'b1) begin failures++; $display("FAIL cor_pop_dead got=%0d/%b exp=0/1", p4d, v4d); end
  endtask

  task automatic test_glider();
    logic [63:0] gl;
    gl = '0; gl[1] = 1'b1; gl[10] = 1'b1; gl[16] = 1'b1; gl[17] = 1'b1; gl[18] = 1'b1;
    birth = 9'h008; survive = 9'h00C; i8 = gl;
    do_load();
    step = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 15) begin
        checks++; if (v8 !== 1'b0) begin failures++; $display("FAIL gl_hold_pv got=%b exp=0", v8); end
      end
    end
    step = 1'b0;
    checks++; if (s8 !== gl) begin failures++; $display("FAIL gl_states got=%h exp=%h", s8, gl); end
    checks++; if (g8 !== 16'd32) begin failures++; $display("FAIL gl_gen got=%0d exp=32", g8); end
    checks++; if (t8 !== 1'b0) begin failures++; $display("FAIL gl_still got=%b exp=0", t8); end
    tick();
    checks++; if (p8 !== 7'd5 || v8 !== 1'b1) begin failures++; $display("FAIL gl_pop got=%0d/%b exp=5/1", p8, v8); end
  endtask

  task automatic test_gen_wrap();
    logic [15:0] blk;
    blk = 16'h0660;
    birth = 9'h008; survive = 9'h00C; ig = blk;
    do_load();
    step = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    step = 1'b0;
    checks++; if (gg !== 3'd1) begin failures++; $display("FAIL gw_gen got=%0d exp=1", gg); end
    checks++; if (sg !== blk) begin failures++; $display("FAIL gw_block got=%h exp=%h", sg, blk); end
    checks++; if (tg !== STILL_EN) begin failures++; $display("FAIL gw_still got=%b exp=%b", tg, STILL_EN); end
    tick();
    checks++; if (pg !== 5'd4 || vg !== 1'b1) begin failures++; $display("FAIL gw_pop got=%0d/%b exp=4/1", pg, vg); end
    ig = 16'h0020;
    load = 1'b1; step = 1'b1; tick(); load = 1'b0; step = 1'b0;
    checks++; if (gg !== 3'd0) begin failures++; $display("FAIL ls_gen got=%0d exp=0", gg); end
    checks++; if (sg !== 16'h0020) begin failures++; $display("FAIL ls_states got=%h exp=0020", sg); end
    checks++; if (tg !== 1'b0) begin failures++; $display("FAIL ls_still got=%b exp=0", tg); end
  endtask

  task automatic test_b1_reset();
    logic [24:0] ring;
    ring = '0;
    ring[6] = 1'b1; ring[7] = 1'b1; ring[8] = 1'b1; ring[11] = 1'b1;
    ring[13] = 1'b1; ring[16] = 1'b1; ring[17] = 1'b1; ring[18] = 1'b1;
    i5d = '0; i5d[12] = 1'b1;
    do_load();
    birth = 9'h002; survive = 9'h000;
    step = 1'b1; tick(); step = 1'b0;
    checks++; if (s5d !== ring) begin failures++; $display("FAIL b1_ring got=%h exp=%h", s5d, ring); end
    checks++; if (t5d !== 1'b0) begin failures++; $display("FAIL b1_still got=%b exp=0", t5d); end
    tick();
    checks++; if (p5d !== 5'd8 || v5d !== 1'b1) begin failures++; $display("FAIL b1_pop got=%0d/%b exp=8/1", p5d, v5d); end
    step = 1'b1; reset = 1'b1; tick(); step = 1'b0; reset = 1'b0;
    checks++; if (s5d !== 25'h0) begin failures++; $display("FAIL mid_rst_states got=%h exp=0", s5d); end
    checks++; if (g5d !== 16'd0) begin failures++; $display("FAIL mid_rst_gen got=%0d exp=0", g5d); end
    checks++; if (p5d !== 5'd0 || v5d !== 1'b1) begin failures++; $display("FAIL mid_rst_pop got=%0d/%b exp=0/1", p5d, v5d); end
    tick();
    checks++; if (s5d !== 25'h0 || p5d !== 5'd0) begin failures++; $display("FAIL post_rst got=%h/%0d exp=0/0", s5d, p5d); end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; step = 1'b0;
    birth = '0; survive = '0;
    i5w = '0; i5d = '0; i4w = '0; i4d = '0; i8 = '0; ig = '0;
    @(negedge clk);
    test_reset();
    test_blinker();
    test_corners();
    test_glider();
    test_gen_wrap();
    test_b1_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
